// File: rtl/pwm_generador_fsw.sv
// Fsw-locked PWM generator: measures the Fsw period and drives a
// double-buffered duty-cycle output aligned to Fsw rising edges.
module pwm_generador_fsw #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Fsw,
  input  logic              Enable,
  input  logic [DUTY_W-1:0] Duty,
  input  logic              Duty_Load,
  output logic              PWM_out,
  output logic [CNT_W-1:0]  Period,
  output logic              Period_Valid,
  output logic              Fault
);

  localparam int unsigned PW = CNT_W + DUTY_W;
  localparam logic [CNT_W-1:0]  CMAX = '1;
  localparam logic [CNT_W-1:0]  CHIT = CMAX - 1'b1;
  localparam logic [DUTY_W-1:0] DMAX = '1;
  localparam logic [CNT_W-1:0]  MINP = CNT_W'(MIN_PERIOD);

  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_first;
  logic [CNT_W-1:0]  r_period;
  logic              r_pv;
  logic              r_fault;
  logic [DUTY_W-1:0] r_shadow;
  logic [DUTY_W-1:0] r_act;
  logic [CNT_W-1:0]  r_thr;
  logic              r_pwm;

  logic              w_rise;
  logic              w_sat;
  logic              w_hit;
  logic [CNT_W-1:0]  w_meas;
  logic [PW-1:0]     w_prod;
  logic [CNT_W-1:0]  w_thr;
  logic              w_accept;
  logic              w_on;

  assign w_rise   = r_s2 & ~r_s3;
  assign w_sat    = (r_cnt == CMAX);
  // Fault fires on the edge where the counter lands on its ceiling.
  assign w_hit    = ~w_rise & (r_cnt == CHIT);
  assign w_meas   = r_cnt + 1'b1;
  assign w_prod   = PW'(w_meas) * PW'(r_shadow);
  assign w_thr    = CNT_W'(w_prod >> DUTY_W);
  assign w_accept = w_rise & r_first & ~w_sat & (w_meas >= MINP);
  assign w_on     = Enable & r_pv & ~r_fault &
                    ((r_act == DMAX) | (r_cnt < r_thr));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= Fsw;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= '0;
    end else if (!w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_shadow <= '0;
    end else if (Duty_Load) begin
      r_shadow <= Duty;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_first  <= 1'b0;
      r_period <= '0;
      r_pv     <= 1'b0;
      r_fault  <= 1'b0;
      r_act    <= '0;
      r_thr    <= '0;
    end else if (w_hit) begin
      r_fault <= 1'b1;
      r_pv    <= 1'b0;
      r_first <= 1'b0;
    end else if (w_rise && !r_first) begin
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_period <= w_meas;
      r_pv     <= 1'b1;
      r_fault  <= 1'b0;
      r_act    <= r_shadow;
      r_thr    <= w_thr;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_on;
    end
  end

  assign PWM_out      = r_pwm;
  assign Period       = r_period;
  assign Period_Valid = r_pv;
  assign Fault        = r_fault;

endmodule

// File: tb/tb_pwm_generador_fsw.sv
// Directed bench for pwm_generador_fsw: lock, duty changes, fault,
// glitch rejection, async reset and enable gating.
module tb_pwm_generador_fsw;

  logic        Clk;
  logic        Reset;
  logic        Fsw;
  logic        Enable;
  logic [7:0]  Duty;
  logic        Duty_Load;
  logic        PWM_out;
  logic [15:0] Period;
  logic        Period_Valid;
  logic        Fault;

  int n_cmp;
  int n_bad;
  int hi;

  pwm_generador_fsw dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Fsw          (Fsw),
    .Enable       (Enable),
    .Duty         (Duty),
    .Duty_Load    (Duty_Load),
    .PWM_out      (PWM_out),
    .Period       (Period),
    .Period_Valid (Period_Valid),
    .Fault        (Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // One Fsw period (50% high) with optional duty load and a
  // short low notch that causes a second rise two cycles later.
  task automatic win(input int per, input int ld_at,
                     input logic [7:0] ld_val, input bit glitch,
                     output int nh);
    nh = 0;
    for (int i = 0; i < per; i++) begin
      Fsw = (i < per / 2) && !(glitch && i == 1);
      Duty_Load = (i == ld_at);
      if (i == ld_at) Duty = ld_val;
      @(posedge Clk);
      #1;
      if (PWM_out === 1'b1) nh++;
    end
    Duty_Load = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b1;
    Fsw = 1'b0;
    Enable = 1'b1;
    Duty = 8'd0;
    Duty_Load = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("rst_pwm", int'(PWM_out), 0);
    chk("rst_period", int'(Period), 0);
    chk("rst_pv", int'(Period_Valid), 0);
    chk("rst_fault", int'(Fault), 0);
    step(3);
    Reset = 1'b1;
    Duty = 8'd128;
    Duty_Load = 1'b1;
    step(1);
    Duty_Load = 1'b0;
    step(3);

    win(100, -1, 8'd0, 0, hi);
    chk("lock_w1_hi", hi, 0);
    chk("lock_w1_pv", int'(Period_Valid), 0);
    win(100, -1, 8'd0, 0, hi);
    chk("lock_w2_hi", hi, 50);
    chk("lock_period", int'(Period), 100);
    chk("lock_pv", int'(Period_Valid), 1);
    win(100, -1, 8'd0, 0, hi);
    chk("lock_w3_hi", hi, 50);

    win(100, 50, 8'd0, 0, hi);
    chk("d0_cur_hi", hi, 50);
    win(100, 50, 8'd255, 0, hi);
    chk("d0_hi", hi, 0);
    win(100, -1, 8'd0, 0, hi);
    chk("d255_first_hi", hi, 97);
    win(100, -1, 8'd0, 0, hi);
    chk("d255_hi", hi, 100);
    chk("d255_pwm", int'(PWM_out), 1);

    win(100, 50, 8'd128, 0, hi);
    chk("d255_tail_hi", hi, 100);
    win(100, 33, 8'd64, 0, hi);
    chk("mid_load_hi", hi, 53);
    win(100, -1, 8'd0, 0, hi);
    chk("d64_hi", hi, 25);
    win(100, -1, 8'd0, 0, hi);
    chk("d64_hi2", hi, 25);

    step(65437);
    chk("presat_fault", int'(Fault), 0);
    chk("presat_pv", int'(Period_Valid), 1);
    step(1);
    chk("sat_fault", int'(Fault), 1);
    chk("sat_pv", int'(Period_Valid), 0);
    step(1);
    chk("sat_pwm", int'(PWM_out), 0);

    win(200, -1, 8'd0, 0, hi);
    chk("rst1_hi", hi, 0);
    chk("rst1_fault", int'(Fault), 1);
    win(200, -1, 8'd0, 0, hi);
    chk("rst2_fault", int'(Fault), 0);
    chk("rst2_period", int'(Period), 200);
    chk("rst2_pv", int'(Period_Valid), 1);
    chk("rst2_hi", hi, 50);

    win(100, -1, 8'd0, 0, hi);
    chk("p200_period", int'(Period), 200);
    chk("p200_hi", hi, 50);
    win(100, -1, 8'd0, 0, hi);
    chk("p100_period", int'(Period), 100);
    chk("p100_hi", hi, 25);
    win(100, -1, 8'd0, 1, hi);
    chk("glitch_period", int'(Period), 100);
    chk("glitch_hi", hi, 27);
    win(100, -1, 8'd0, 0, hi);
    chk("post_gl_period", int'(Period), 98);
    chk("post_gl_hi", hi, 24);
    win(100, -1, 8'd0, 0, hi);
    chk("p100b_hi", hi, 25);

    Fsw = 1'b1;
    step(10);
    chk("mid_high_pwm", int'(PWM_out), 1);
    Reset = 1'b0;
    #1;
    chk("async_pwm", int'(PWM_out), 0);
    chk("async_period", int'(Period), 0);
    chk("async_pv", int'(Period_Valid), 0);
    Fsw = 1'b0;
    step(5);
    Reset = 1'b1;
    Duty = 8'd128;
    Duty_Load = 1'b1;
    step(1);
    Duty_Load = 1'b0;
    step(2);
    win(100, -1, 8'd0, 0, hi);
    chk("re_w1_hi", hi, 0);
    chk("re_w1_pv", int'(Period_Valid), 0);
    win(100, -1, 8'd0, 0, hi);
    chk("re_w2_hi", hi, 50);
    chk("re_w2_period", int'(Period), 100);

    Enable = 1'b0;
    win(100, -1, 8'd0, 0, hi);
    chk("en0_hi", hi, 0);
    chk("en0_pv", int'(Period_Valid), 1);
    chk("en0_fault", int'(Fault), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
